// File: rtl/mbox_arbiter.sv
//------------------------------------------------------------------------------
// mbox_arbiter: two-requester round-robin mailbox with credit and error flags.
// Optional MBOX_SRC_TAG_EN stores the requester id with each entry (rd_src).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mbox_arbiter #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int PROG_FULL = 4
) (
  input  logic                         clk,
  input  logic                         reset_p,
  input  logic [WIDTH-1:0]             req0_data,
  input  logic                         req0_we,
  output logic                         req0_ready,
  input  logic [WIDTH-1:0]             req1_data,
  input  logic                         req1_we,
  output logic                         req1_ready,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  input  logic                         rd_pop,
  output logic                         rd_src,
  output logic [$clog2(DEPTH+1)-1:0]   credit,
  output logic                         prog_full,
  output logic                         full,
  output logic                         err_drop,
  output logic                         err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
`ifdef MBOX_SRC_TAG_EN
  localparam int ENTRY_W = WIDTH + 1;
`else
  localparam int ENTRY_W = WIDTH;
`endif
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL);

  logic               pend0_valid_q, pend0_valid_d;
  logic [WIDTH-1:0]   pend0_data_q,  pend0_data_d;
  logic               pend1_valid_q, pend1_valid_d;
  logic [WIDTH-1:0]   pend1_data_q,  pend1_data_d;
  logic               last_grant_q,  last_grant_d;
  logic [PTR_W-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,      rd_ptr_d;
  logic [CW-1:0]      credit_q,      credit_d;
  logic               err_drop_q,    err_drop_d;
  logic               err_under_q,   err_under_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_wdata_d;

  logic             gnt_any;
  logic             gnt_src;
  logic             tie;
  logic             pop_ok;
  logic [WIDTH-1:0] gnt_data;

  always_comb begin
    pend0_valid_d = pend0_valid_q;
    pend0_data_d  = pend0_data_q;
    pend1_valid_d = pend1_valid_q;
    pend1_data_d  = pend1_data_q;
    last_grant_d  = last_grant_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    credit_d      = credit_q;
    err_drop_d    = err_drop_q;
    err_under_d   = err_under_q;

    // Grant decision uses registered credit, so a pop at credit 0 only frees a slot next cycle.
    tie      = pend0_valid_q & pend1_valid_q;
    gnt_any  = (credit_q != '0) & (pend0_valid_q | pend1_valid_q);
    gnt_src  = tie ? ~last_grant_q : pend1_valid_q;
    gnt_data = gnt_src ? pend1_data_q : pend0_data_q;
    pop_ok   = rd_pop & rd_valid;
`ifdef MBOX_SRC_TAG_EN
    mem_wdata_d = {gnt_src, gnt_data};
`else
    mem_wdata_d = gnt_data;
`endif

    if (gnt_any) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (gnt_src) pend1_valid_d = 1'b0;
      else         pend0_valid_d = 1'b0;
      // The round-robin pointer only tracks tie winners.
      if (tie) last_grant_d = gnt_src;
    end

    if (req0_we) begin
      if (pend0_valid_q) err_drop_d = 1'b1;
      else begin
        pend0_valid_d = 1'b1;
        pend0_data_d  = req0_data;
      end
    end
    if (req1_we) begin
      if (pend1_valid_q) err_drop_d = 1'b1;
      else begin
        pend1_valid_d = 1'b1;
        pend1_data_d  = req1_data;
      end
    end

    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (rd_pop & ~rd_valid) err_under_d = 1'b1;

    case ({gnt_any, pop_ok})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      pend0_valid_q <= 1'b0;
      pend0_data_q  <= '0;
      pend1_valid_q <= 1'b0;
      pend1_data_q  <= '0;
      last_grant_q  <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      credit_q      <= DEPTH_C;
      err_drop_q    <= 1'b0;
      err_under_q   <= 1'b0;
    end else begin
      pend0_valid_q <= pend0_valid_d;
      pend0_data_q  <= pend0_data_d;
      pend1_valid_q <= pend1_valid_d;
      pend1_data_q  <= pend1_data_d;
      last_grant_q  <= last_grant_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      credit_q      <= credit_d;
      err_drop_q    <= err_drop_d;
      err_under_q   <= err_under_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_p && gnt_any) mem_q[wr_ptr_q] <= mem_wdata_d;
  end

  assign req0_ready    = ~pend0_valid_q;
  assign req1_ready    = ~pend1_valid_q;
  assign rd_data       = mem_q[rd_ptr_q][WIDTH-1:0];
`ifdef MBOX_SRC_TAG_EN
  assign rd_src        = mem_q[rd_ptr_q][WIDTH];
`else
  assign rd_src        = 1'b0;
`endif
  assign credit        = credit_q;
  assign rd_valid      = (credit_q != DEPTH_C);
  assign full          = (credit_q == '0);
  assign prog_full     = ((DEPTH_C - credit_q) >= PF_C);
  assign err_drop      = err_drop_q;
  assign err_underflow = err_under_q;

endmodule

`default_nettype wire

// File: tb/tb_mbox_arbiter.sv
//------------------------------------------------------------------------------
// tb_mbox_arbiter: directed vector table plus fill/drop/reset sequences.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mbox_arbiter;

`ifdef MBOX_SRC_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_p;
  logic [31:0] req0_data, req1_data, rd_data;
  logic        req0_we, req1_we, req0_ready, req1_ready;
  logic        rd_valid, rd_pop, rd_src, prog_full, full, err_drop, err_underflow;
  logic [3:0]  credit;

  int n_chk = 0;
  int n_err = 0;

  mbox_arbiter #(.WIDTH(32), .DEPTH(8), .PROG_FULL(4)) dut (
    .clk(clk), .reset_p(reset_p),
    .req0_data(req0_data), .req0_we(req0_we), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_we(req1_we), .req1_ready(req1_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_pop(rd_pop), .rd_src(rd_src),
    .credit(credit), .prog_full(prog_full), .full(full),
    .err_drop(err_drop), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we0;
    logic [31:0] d0;
    logic        we1;
    logic [31:0] d1;
    logic        pop;
    logic        cd;
    logic        ev;
    logic [31:0] ed;
    logic        es;
    logic [3:0]  ec;
    logic        er0;
    logic        er1;
    logic        edr;
    logic        eun;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    reset_p = 1'b0;
    req0_we = 1'b0;
    req1_we = 1'b0;
    rd_pop  = 1'b0;
  endtask

  initial begin
    //           rst   we0   d0      we1   d1      pop   cd    ev    ed      es    ec    er0   er1   edr   eun
    tv[0]  = '{1'b0, 1'b1, 32'h11, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 32'hA0, 1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 32'hA0, 1'b1, 32'hB1, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1};

    reset_p = 1'b1; req0_we = 1'b0; req1_we = 1'b0; rd_pop = 1'b0;
    req0_data = '0; req1_data = '0;
    @(posedge clk); #1;
    reset_p = 1'b1;
    tick();
    chk("rst_credit", 32'(credit), 32'd8);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_pfull", 32'(prog_full), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd1);
    chk("rst_ready1", 32'(req1_ready), 32'd1);
    chk("rst_errs", {30'd0, err_drop, err_underflow}, 32'd0);

    for (int k = 0; k < 14; k++) begin
      reset_p   = tv[k].rst;
      req0_we   = tv[k].we0;
      req0_data = tv[k].d0;
      req1_we   = tv[k].we1;
      req1_data = tv[k].d1;
      rd_pop    = tv[k].pop;
      tick();
      if (tv[k].cd) begin
        chk($sformatf("v%0d_data", k), rd_data, tv[k].ed);
        chk($sformatf("v%0d_src", k), 32'(rd_src), TAG ? 32'(tv[k].es) : 32'd0);
      end
      chk($sformatf("v%0d_valid", k), 32'(rd_valid), 32'(tv[k].ev));
      chk($sformatf("v%0d_credit", k), 32'(credit), 32'(tv[k].ec));
      chk($sformatf("v%0d_ready0", k), 32'(req0_ready), 32'(tv[k].er0));
      chk($sformatf("v%0d_ready1", k), 32'(req1_ready), 32'(tv[k].er1));
      chk($sformatf("v%0d_errdrop", k), 32'(err_drop), 32'(tv[k].edr));
      chk($sformatf("v%0d_errunder", k), 32'(err_underflow), 32'(tv[k].eun));
      chk($sformatf("v%0d_full", k), 32'(full), 32'd0);
      chk($sformatf("v%0d_pfull", k), 32'(prog_full), 32'd0);
    end

    // Fill to capacity with alternating requesters; the 9th stalls in pending.
    reset_p = 1'b1;
    tick();
    chk("fill_rst_errs", {30'd0, err_drop, err_underflow}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) begin req0_we = 1'b1; req0_data = 32'h100 + i; end
      else            begin req1_we = 1'b1; req1_data = 32'h100 + i; end
      tick();
      chk($sformatf("fill%0d_credit", i), 32'(credit), 32'(8 - i));
      chk($sformatf("fill%0d_pfull", i), 32'(prog_full), (i >= 4) ? 32'd1 : 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready0", 32'(req0_ready), 32'd0);
    chk("fill_ready1", 32'(req1_ready), 32'd1);

    req0_we = 1'b1; req0_data = 32'h109;
    tick();
    chk("drop_err", 32'(err_drop), 32'd1);
    chk("drop_credit", 32'(credit), 32'd0);
    chk("drop_ready0", 32'(req0_ready), 32'd0);

    rd_pop = 1'b1;
    tick();
    chk("pop_credit", 32'(credit), 32'd1);
    chk("pop_full", 32'(full), 32'd0);
    chk("pop_ready0", 32'(req0_ready), 32'd0);
    chk("pop_head", rd_data, 32'h101);
    tick();
    chk("regrant_credit", 32'(credit), 32'd0);
    chk("regrant_full", 32'(full), 32'd1);
    chk("regrant_ready0", 32'(req0_ready), 32'd1);

    for (int j = 1; j <= 8; j++) begin
      chk($sformatf("drain%0d_data", j), rd_data, 32'h100 + j);
      chk($sformatf("drain%0d_src", j), 32'(rd_src), TAG ? 32'(j % 2) : 32'd0);
      rd_pop = 1'b1;
      tick();
    end
    chk("drain_valid", 32'(rd_valid), 32'd0);
    chk("drain_credit", 32'(credit), 32'd8);
    rd_pop = 1'b1;
    tick();
    chk("under_err", 32'(err_underflow), 32'd1);
    chk("under_credit", 32'(credit), 32'd8);

    // Reset with five buffered entries and both pending slots occupied.
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin req0_we = 1'b1; req0_data = 32'h200 + i; end
      else            begin req1_we = 1'b1; req1_data = 32'h200 + i; end
      tick();
    end
    tick();
    req0_we = 1'b1; req0_data = 32'h2A0;
    req1_we = 1'b1; req1_data = 32'h2B1;
    tick();
    chk("mid_credit", 32'(credit), 32'd3);
    chk("mid_pfull", 32'(prog_full), 32'd1);
    chk("mid_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    chk("mid_errs", {30'd0, err_drop, err_underflow}, 32'd3);
    reset_p = 1'b1;
    tick();
    chk("mrst_credit", 32'(credit), 32'd8);
    chk("mrst_valid", 32'(rd_valid), 32'd0);
    chk("mrst_ready", {30'd0, req0_ready, req1_ready}, 32'd3);
    chk("mrst_errs", {30'd0, err_drop, err_underflow}, 32'd0);
    chk("mrst_flags", {30'd0, full, prog_full}, 32'd0);
    tick();
    chk("mrst_idle_credit", 32'(credit), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
